// File: rtl/timer_pkg.sv
// Shared definitions for the timer device: register offsets, CTRL bit
// positions, MODE encodings and the FSM state encoding.
package timer_pkg;

  // Word offsets within the register window (addr[3:2]).
  localparam logic [1:0] OFF_CTRL   = 2'b00;
  localparam logic [1:0] OFF_PRESET = 2'b01;
  localparam logic [1:0] OFF_COUNT  = 2'b10;
  localparam logic [1:0] OFF_NONE   = 2'b11;

  // CTRL bit positions.
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  // MODE encodings; anything other than one-shot behaves as auto-reload.
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } timer_state_e;

  // True when the timer should re-arm itself after expiring.
  function automatic logic mode_is_reload(input logic [1:0] mode);
    return mode != MODE_ONESHOT;
  endfunction

endpackage

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer with one-shot and auto-reload modes and a
// maskable interrupt. CTRL/PRESET are CPU-writable, COUNT is read-only.
//
// Bus semantics: there is no valid/ready handshake. A write takes effect on
// the rising edge where we=1 and addr hits a writable register; it is always
// accepted in that cycle. Reads are purely combinational from addr.
module timer_dev
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq,
  output logic [1:0]  dbg_state
);

  // Register state.
  logic         r_en;
  logic [1:0]   r_mode;
  logic         r_im;
  logic [31:0]  r_preset;
  logic [31:0]  r_count;
  logic         r_irq_flag;
  timer_state_e r_state;

  // Address decode.
  logic       w_hit;
  logic [1:0] w_off;
  logic       w_ctrl_wr;
  logic       w_preset_wr;
  logic       w_unused;

  assign w_off       = addr[3:2];
  assign w_hit       = (addr[31:4] == BASE_ADDR[31:4]) && (w_off != OFF_NONE);
  assign w_ctrl_wr   = we && w_hit && (w_off == OFF_CTRL);
  assign w_preset_wr = we && w_hit && (w_off == OFF_PRESET);

  // Byte-lane bits and upper CTRL write bits carry no meaning here.
  assign w_unused = ^{addr[1:0], din[31:4]};

  // PRESET register: only reloaded into COUNT on the next LOAD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_preset <= '0;
    end else if (w_preset_wr) begin
      r_preset <= din;
    end
  end

  // Timer FSM together with CTRL and IRQ_FLAG. The CPU write block comes
  // last so that a CTRL write overrides any FSM update on the same edge
  // (both the EN clear in one-shot INT and the flag set in CNT).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en       <= 1'b0;
      r_mode     <= MODE_ONESHOT;
      r_im       <= 1'b0;
      r_count    <= '0;
      r_irq_flag <= 1'b0;
      r_state    <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_en) begin
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_count <= r_preset;
          r_state <= ST_CNT;
        end
        ST_CNT: begin
          if (!r_en) begin
            // Disabled mid-count: COUNT keeps its value.
            r_state <= ST_IDLE;
          end else if (r_count > 32'd1) begin
            r_count <= r_count - 32'd1;
          end else begin
            // Covers COUNT of 1 and 0, so PRESET=0 expires like PRESET=1
            // and the counter can never wrap.
            r_count    <= '0;
            r_irq_flag <= 1'b1;
            r_state    <= ST_INT;
          end
        end
        ST_INT: begin
          if (mode_is_reload(r_mode)) begin
            // EN stays set, so IDLE moves straight on to a reload.
            r_irq_flag <= 1'b0;
          end else begin
            // One-shot: the flag stays pending until software writes CTRL.
            r_en <= 1'b0;
          end
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase

      if (w_ctrl_wr) begin
        r_en       <= din[CTRL_EN];
        r_mode     <= din[CTRL_MODE_HI:CTRL_MODE_LO];
        r_im       <= din[CTRL_IM];
        r_irq_flag <= 1'b0;
      end
    end
  end

  // Combinational read mux; misses and the unmapped slot read as zero.
  always_comb begin
    dout = '0;
    if (w_hit) begin
      case (w_off)
        OFF_CTRL:   dout = {28'd0, r_im, r_mode, r_en};
        OFF_PRESET: dout = r_preset;
        OFF_COUNT:  dout = r_count;
        default:    dout = '0;
      endcase
    end
  end

  assign irq       = r_irq_flag & r_im;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev: a register-access vector table followed by
// hand-written timing sequences for one-shot, auto-reload, masking, reset
// and same-edge priority cases.
module tb_timer_dev;

  localparam logic [31:0] BASE = 32'h0000_7F00;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  timer_dev #(.BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .we        (we),
    .din       (din),
    .dout      (dout),
    .irq       (irq),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        is_wr;
    logic [31:0] a;
    logic [31:0] data;  // write data, or expected read data
    string       name;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One clock cycle: inputs set at the falling edge, released #1 after the rising edge.
  task automatic step(input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    we   = w;
    addr = a;
    din  = d;
    @(posedge clk);
    #1;
    we  = 1'b0;
    din = '0;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 32'h0);
  endtask

  // Combinational read away from any clock edge; consumes no cycles.
  task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(name, dout, exp);
  endtask

  initial begin
    reset = 1'b0;
    we    = 1'b0;
    addr  = '0;
    din   = '0;

    vecs[0]  = '{1'b0, BASE + 32'h0, 32'h0000_0000, "rst_ctrl"};
    vecs[1]  = '{1'b0, BASE + 32'h4, 32'h0000_0000, "rst_preset"};
    vecs[2]  = '{1'b0, BASE + 32'h8, 32'h0000_0000, "rst_count"};
    vecs[3]  = '{1'b1, BASE + 32'h4, 32'h1234_5678, "wr_preset"};
    vecs[4]  = '{1'b0, BASE + 32'h4, 32'h1234_5678, "preset_rw"};
    vecs[5]  = '{1'b0, BASE + 32'h7, 32'h1234_5678, "preset_lowbits"};
    vecs[6]  = '{1'b1, BASE + 32'h0, 32'hFFFF_FFF6, "wr_ctrl"};
    vecs[7]  = '{1'b0, BASE + 32'h0, 32'h0000_0006, "ctrl_mask"};
    vecs[8]  = '{1'b1, BASE + 32'h8, 32'h0000_FFFF, "wr_count"};
    vecs[9]  = '{1'b0, BASE + 32'h8, 32'h0000_0000, "count_ro"};
    vecs[10] = '{1'b0, BASE + 32'hC, 32'h0000_0000, "unmapped_c"};
    vecs[11] = '{1'b0, 32'h0000_7F10, 32'h0000_0000, "outside_hi"};
    vecs[12] = '{1'b1, BASE + 32'hC, 32'hAAAA_5555, "wr_unmapped"};
    vecs[13] = '{1'b1, 32'h0000_7E04, 32'h0000_0001, "wr_outside"};
    vecs[14] = '{1'b0, BASE + 32'h4, 32'h1234_5678, "preset_kept"};
    vecs[15] = '{1'b0, BASE + 32'h0, 32'h0000_0006, "ctrl_kept"};
    vecs[16] = '{1'b1, BASE + 32'h0, 32'h0000_0000, "wr_ctrl0"};
    vecs[17] = '{1'b0, BASE + 32'h0, 32'h0000_0000, "ctrl_clear"};
    vecs[18] = '{1'b1, BASE + 32'h4, 32'h0000_0000, "wr_preset0"};

    // Reset state while reset is held.
    repeat (2) @(posedge clk);
    #1;
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Register access table; EN never set so the FSM must stay idle.
    for (int i = 0; i < 19; i++) begin
      if (vecs[i].is_wr) begin
        step(1'b1, vecs[i].a, vecs[i].data);
      end else begin
        read_check(vecs[i].name, vecs[i].a, vecs[i].data);
      end
    end
    check("tbl_irq", {31'd0, irq}, 32'd0);
    check("tbl_state", {30'd0, dbg_state}, 32'd0);

    // One-shot, PRESET=5: irq rises after 7 edges and stays high.
    step(1'b1, BASE + 32'h4, 32'd5);
    step(1'b1, BASE + 32'h0, 32'h9);
    for (int k = 1; k <= 10; k++) begin
      idle();
      check($sformatf("oneshot_irq_k%0d", k), {31'd0, irq}, {31'd0, k >= 7});
    end
    read_check("oneshot_ctrl", BASE + 32'h0, 32'h8);
    read_check("oneshot_count", BASE + 32'h8, 32'h0);
    check("oneshot_state", {30'd0, dbg_state}, 32'd0);

    // Clearing CTRL drops the pending irq on the next edge; nothing follows.
    step(1'b1, BASE + 32'h0, 32'h0);
    check("clr_irq", {31'd0, irq}, 32'd0);
    for (int k = 1; k <= 8; k++) begin
      idle();
      check($sformatf("clr_quiet_k%0d", k), {31'd0, irq}, 32'd0);
    end

    // Auto-reload, PRESET=3: single-cycle pulses every 6 cycles.
    step(1'b1, BASE + 32'h4, 32'd3);
    step(1'b1, BASE + 32'h0, 32'hB);
    for (int k = 1; k <= 30; k++) begin
      idle();
      check($sformatf("reload_irq_k%0d", k), {31'd0, irq},
            {31'd0, (k >= 5) && (((k - 5) % 6) == 0)});
    end
    step(1'b1, BASE + 32'h0, 32'h0);
    repeat (4) idle();
    check("reload_stop_irq", {31'd0, irq}, 32'd0);

    // Masked expiry: flag sets invisibly; a CTRL write clears it and restarts.
    step(1'b1, BASE + 32'h4, 32'd10);
    step(1'b1, BASE + 32'h0, 32'h1);
    for (int k = 1; k <= 15; k++) begin
      idle();
      check($sformatf("masked_irq_k%0d", k), {31'd0, irq}, 32'd0);
    end
    read_check("masked_ctrl", BASE + 32'h0, 32'h0);
    step(1'b1, BASE + 32'h0, 32'h9);
    for (int k = 1; k <= 13; k++) begin
      idle();
      check($sformatf("unmask_irq_k%0d", k), {31'd0, irq}, {31'd0, k >= 12});
    end
    step(1'b1, BASE + 32'h0, 32'h0);

    // PRESET=0 expires like PRESET=1.
    step(1'b1, BASE + 32'h4, 32'd0);
    step(1'b1, BASE + 32'h0, 32'h9);
    for (int k = 1; k <= 4; k++) begin
      idle();
      check($sformatf("p0_irq_k%0d", k), {31'd0, irq}, {31'd0, k >= 3});
    end
    read_check("p0_count", BASE + 32'h8, 32'h0);
    step(1'b1, BASE + 32'h0, 32'h0);

    // CTRL write on the same edge the one-shot INT state clears EN.
    step(1'b1, BASE + 32'h4, 32'd2);
    step(1'b1, BASE + 32'h0, 32'h9);
    for (int k = 1; k <= 4; k++) begin
      idle();
      check($sformatf("race_pre_k%0d", k), {31'd0, irq}, {31'd0, k >= 4});
    end
    step(1'b1, BASE + 32'h0, 32'h9);
    check("race_irq_cleared", {31'd0, irq}, 32'd0);
    read_check("race_ctrl", BASE + 32'h0, 32'h9);
    for (int k = 1; k <= 4; k++) begin
      idle();
      check($sformatf("race_post_k%0d", k), {31'd0, irq}, {31'd0, k >= 4});
    end
    step(1'b1, BASE + 32'h0, 32'h0);
    repeat (2) idle();

    // PRESET write during CNT only affects the following reload.
    step(1'b1, BASE + 32'h4, 32'd6);
    step(1'b1, BASE + 32'h0, 32'hB);
    for (int k = 1; k <= 19; k++) begin
      if (k == 4) step(1'b1, BASE + 32'h4, 32'd2);
      else idle();
      check($sformatf("preset_mid_k%0d", k), {31'd0, irq},
            {31'd0, (k == 8) || (k == 13) || (k == 18)});
    end
    step(1'b1, BASE + 32'h0, 32'h0);
    repeat (3) idle();

    // Reset pulse mid-count (COUNT=4) aborts everything.
    step(1'b1, BASE + 32'h4, 32'd8);
    step(1'b1, BASE + 32'h0, 32'h9);
    repeat (6) idle();
    read_check("mid_count", BASE + 32'h8, 32'd4);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("arst_irq", {31'd0, irq}, 32'd0);
    check("arst_state", {30'd0, dbg_state}, 32'd0);
    read_check("arst_ctrl", BASE + 32'h0, 32'h0);
    read_check("arst_preset", BASE + 32'h4, 32'h0);
    read_check("arst_count", BASE + 32'h8, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      idle();
      check($sformatf("post_rst_irq_k%0d", k), {31'd0, irq}, 32'd0);
    end
    check("post_rst_state", {30'd0, dbg_state}, 32'd0);
    read_check("post_rst_count", BASE + 32'h8, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
